// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF    = 16;
  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned TIMEOUT_DEF   = 255;
  localparam int unsigned RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    REDIR,
    HALTED
  } state_e;

  // Counter width able to hold 0..t-1 (at least one bit).
  function automatic int unsigned tmo_w(input int unsigned t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

  localparam int unsigned TMO_W = tmo_w(TIMEOUT_DEF);

endpackage

// File: rtl/fetch_sequencer_if.sv
// PC / imem / decode / control signals of the fetch sequencer; RET_STACK_EN adds call_push, ret_pop.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              pc_load;
  logic [ADDR_W-1:0] pc_count;
  logic [ADDR_W-1:0] pc_data;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              halt;
  logic              halted;
  logic              fetch_err;
`ifdef RET_STACK_EN
  logic              call_push;
  logic              ret_pop;
`endif

  modport master (
`ifdef RET_STACK_EN
    input  call_push, ret_pop,
`endif
    input  pc_count, imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target, halt,
    output pc_load, pc_data, imem_req, imem_addr, instr_valid, instr, instr_pc, halted, fetch_err
  );

  modport slave (
`ifdef RET_STACK_EN
    output call_push, ret_pop,
`endif
    output pc_count, imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_target, halt,
    input  pc_load, pc_data, imem_req, imem_addr, instr_valid, instr, instr_pc, halted, fetch_err
  );
endinterface

// File: rtl/fetch_sequencer_ret_stack.sv
// Circular return-address LIFO; a push when full overwrites the oldest entry.
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] top
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] nxt_ptr;
  logic [CNT_W-1:0] cnt;

  assign top_ptr = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - 1'b1;
  assign nxt_ptr = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign empty   = (cnt == '0);
  assign top     = mem[top_ptr];

  // Push+pop on a non-empty stack replaces the top in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push && pop && !empty) begin
      mem[top_ptr] <= push_data;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= nxt_ptr;
      if (cnt != CNT_W'(DEPTH)) cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      cnt    <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: holds/advances the PC, issues imem reads, hands words to decode.
// Optional return-address stack enabled by defining RET_STACK_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
`ifdef RET_STACK_EN
  , parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
`endif
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);
  localparam int unsigned CNT_W = tmo_w(TIMEOUT);

  state_e            state;
  state_e            state_nx;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              redir;
  logic              take;
  logic              accept;
  logic              tmo;
  logic [ADDR_W-1:0] redir_pc;

  assign redir = bus.redirect_valid & ~rst;

`ifdef RET_STACK_EN
  logic              ras_push;
  logic              ras_pop;
  logic              ras_empty;
  logic [ADDR_W-1:0] ras_top;

  assign ras_pop  = redir & bus.ret_pop;
  assign ras_push = accept & bus.call_push;
  assign redir_pc = (ras_pop && !ras_empty) ? ras_top : bus.redirect_target;

  ret_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .push_data (bus.instr_pc + ADDR_W'(1)),
    .pop       (ras_pop),
    .empty     (ras_empty),
    .top       (ras_top)
  );
`else
  assign redir_pc = bus.redirect_target;
`endif

  // Next state and PC control; a redirect overrides everything else.
  always_comb begin
    state_nx      = state;
    bus.pc_load   = 1'b1;
    bus.pc_data   = bus.pc_count;
    bus.imem_req  = (state == FETCH);
    bus.imem_addr = (state == FETCH) ? bus.pc_count : '0;
    bus.halted    = (state == HALTED);
    take          = 1'b0;
    accept        = 1'b0;
    tmo           = 1'b0;
    case (state)
      IDLE:   state_nx = bus.halt ? HALTED : FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          take        = 1'b1;
          bus.pc_load = 1'b0;
          state_nx    = HOLD;
        end else if (TIMEOUT != 0 && tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
          tmo      = 1'b1;
          state_nx = REDIR;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          accept   = 1'b1;
          state_nx = bus.halt ? HALTED : FETCH;
        end
      end
      REDIR:  state_nx = FETCH;
      HALTED: if (!bus.halt) state_nx = FETCH;
      default: state_nx = IDLE;
    endcase
    if (redir) begin
      bus.pc_load = 1'b1;
      bus.pc_data = redir_pc;
      take        = 1'b0;
      accept      = 1'b0;
      tmo         = 1'b0;
      case (state)
        FETCH:   state_nx = REDIR;
        HALTED:  state_nx = HALTED;
        default: state_nx = FETCH;
      endcase
    end
  end

  // State, wait counter, captured instruction and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      tmo_cnt         <= '0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      bus.fetch_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= (state == FETCH && state_nx == FETCH) ? tmo_cnt + 1'b1 : '0;
      if (take) begin
        bus.instr       <= bus.imem_rdata;
        bus.instr_pc    <= bus.pc_count;
        bus.instr_valid <= 1'b1;
      end else if (accept || redir) begin
        bus.instr_valid <= 1'b0;
      end
      if (redir)    bus.fetch_err <= 1'b0;
      else if (tmo) bus.fetch_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed cycle table, randomized imem/decode traffic vs a delivery model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Program counter the sequencer controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pc <= 16'h0000;
    else if (bus.pc_load) pc <= bus.pc_data;
    else                  pc <= pc + 16'd1;
  end
  assign bus.pc_count = pc;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'h1234;
  endfunction

  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        rdy;
    logic        hlt;
    logic        rv;
    logic [15:0] tgt;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_val;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
    logic [15:0] e_pc;
    logic        e_halted;
    logic        e_err;
  } vec_t;

  vec_t vecs[24];

  task automatic clr_in();
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = 16'h0000;
    bus.instr_ready     = 1'b0;
    bus.halt            = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 16'h0000;
`ifdef RET_STACK_EN
    bus.call_push       = 1'b0;
    bus.ret_pop         = 1'b0;
`endif
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_load"},   16'(bus.pc_load), 16'h0001);
    chk({tag, "_pc_data"},   bus.pc_data, pc);
    chk({tag, "_req"},       16'(bus.imem_req), 16'h0000);
    chk({tag, "_addr"},      bus.imem_addr, 16'h0000);
    chk({tag, "_valid"},     16'(bus.instr_valid), 16'h0000);
    chk({tag, "_instr"},     bus.instr, 16'h0000);
    chk({tag, "_instr_pc"},  bus.instr_pc, 16'h0000);
    chk({tag, "_halted"},    16'(bus.halted), 16'h0000);
    chk({tag, "_fetch_err"}, 16'(bus.fetch_err), 16'h0000);
  endtask

  initial begin
    vec_t        v;
    int          req_cnt;
    int          lat;
    int          n_acc;
    int          r;
    bit          tmo_pend;
    bit          exp_err;
    logic [15:0] exp_pc;
    logic [15:0] tgt;

    // ack, rdata, rdy, hlt, rv, tgt | req, addr, valid, instr, instr_pc, pc, halted, err
    vecs[0]  = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0};
    vecs[1]  = '{1'b1,16'h1234,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0};
    vecs[2]  = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0001,1'b0,1'b0};
    vecs[3]  = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0001,1'b0,1'b0};
    vecs[4]  = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0001,1'b0,1'b0};
    vecs[5]  = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0001,1'b0,1'b0};
    vecs[6]  = '{1'b0,16'h0000,1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h1234,16'h0000,16'h0001,1'b0,1'b0};
    vecs[7]  = '{1'b1,16'h1235,1'b0,1'b0,1'b1,16'h00A0, 1'b1,16'h0001,1'b0,16'h1234,16'h0000,16'h0001,1'b0,1'b0};
    vecs[8]  = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h1234,16'h0000,16'h00A0,1'b0,1'b0};
    vecs[9]  = '{1'b1,16'h1294,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h00A0,1'b0,16'h1234,16'h0000,16'h00A0,1'b0,1'b0};
    vecs[10] = '{1'b0,16'h0000,1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h1294,16'h00A0,16'h00A1,1'b0,1'b0};
    vecs[11] = '{1'b0,16'h0000,1'b1,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h1294,16'h00A0,16'h00A1,1'b0,1'b0};
    vecs[12] = '{1'b0,16'h0000,1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h1294,16'h00A0,16'h00A1,1'b1,1'b0};
    vecs[13] = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h1294,16'h00A0,16'h00A1,1'b1,1'b0};
    vecs[14] = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h00A1,1'b0,16'h1294,16'h00A0,16'h00A1,1'b0,1'b0};
    vecs[15] = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h00A1,1'b0,16'h1294,16'h00A0,16'h00A1,1'b0,1'b0};
    vecs[16] = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h00A1,1'b0,16'h1294,16'h00A0,16'h00A1,1'b0,1'b0};
    vecs[17] = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h00A1,1'b0,16'h1294,16'h00A0,16'h00A1,1'b0,1'b0};
    vecs[18] = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b0,16'h1294,16'h00A0,16'h00A1,1'b0,1'b1};
    vecs[19] = '{1'b1,16'h1295,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h00A1,1'b0,16'h1294,16'h00A0,16'h00A1,1'b0,1'b1};
    vecs[20] = '{1'b0,16'h0000,1'b0,1'b0,1'b1,16'hFFFF, 1'b0,16'h0000,1'b1,16'h1295,16'h00A1,16'h00A2,1'b0,1'b1};
    vecs[21] = '{1'b1,16'hEDCB,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'hFFFF,1'b0,16'h1295,16'h00A1,16'hFFFF,1'b0,1'b0};
    vecs[22] = '{1'b0,16'h0000,1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'hEDCB,16'hFFFF,16'h0000,1'b0,1'b0};
    vecs[23] = '{1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'hEDCB,16'hFFFF,16'h0000,1'b0,1'b0};

    rst = 1'b1;
    clr_in();
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // Directed cycle table: check outputs, then drive this row's inputs.
    for (int i = 0; i < 24; i++) begin
      v = vecs[i];
      chk($sformatf("row%0d_req", i), 16'(bus.imem_req), 16'(v.e_req));
      if (v.e_req) chk($sformatf("row%0d_addr", i), bus.imem_addr, v.e_addr);
      chk($sformatf("row%0d_valid", i), 16'(bus.instr_valid), 16'(v.e_val));
      chk($sformatf("row%0d_instr", i), bus.instr, v.e_instr);
      chk($sformatf("row%0d_instr_pc", i), bus.instr_pc, v.e_ipc);
      chk($sformatf("row%0d_pc", i), pc, v.e_pc);
      chk($sformatf("row%0d_halted", i), 16'(bus.halted), 16'(v.e_halted));
      chk($sformatf("row%0d_err", i), 16'(bus.fetch_err), 16'(v.e_err));
      bus.imem_ack        = v.ack;
      bus.imem_rdata      = v.rdata;
      bus.instr_ready     = v.rdy;
      bus.halt            = v.hlt;
      bus.redirect_valid  = v.rv;
      bus.redirect_target = v.tgt;
      @(negedge clk);
    end

    // Reset while a read is outstanding.
    clr_in();
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic: model tracks the next address decode must receive.
    exp_pc   = 16'h0000;
    exp_err  = 1'b0;
    req_cnt  = 0;
    lat      = 1;
    tmo_pend = 1'b0;
    n_acc    = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      clr_in();
      if (tmo_pend) begin
        chk("rand_tmo_gap", 16'(bus.imem_req), 16'h0000);
        chk("rand_tmo_err", 16'(bus.fetch_err), 16'h0001);
        exp_err  = 1'b1;
        tmo_pend = 1'b0;
      end else if (bus.imem_req) begin
        chk("rand_addr", bus.imem_addr, exp_pc);
        if (req_cnt == 0) lat = $urandom_range(1, 6);
        req_cnt++;
        if (req_cnt == lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = memf(bus.imem_addr);
          req_cnt        = 0;
        end else if (req_cnt == int'(TMO)) begin
          tmo_pend = 1'b1;
          req_cnt  = 0;
        end
      end
      if (bus.instr_valid) begin
        chk("rand_pc_hold", pc, 16'(exp_pc + 16'd1));
        r = $urandom_range(0, 7);
        if (r == 0) begin
          tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
          bus.redirect_valid  = 1'b1;
          bus.redirect_target = tgt;
          exp_pc  = tgt;
          exp_err = 1'b0;
        end else if (r <= 4) begin
          bus.instr_ready = 1'b1;
          chk("rand_instr", bus.instr, memf(exp_pc));
          chk("rand_instr_pc", bus.instr_pc, exp_pc);
          chk("rand_err", 16'(bus.fetch_err), 16'(exp_err));
          exp_pc = exp_pc + 16'd1;
          n_acc++;
        end
      end
      @(negedge clk);
    end
    chk("rand_progress", 16'(n_acc > 200), 16'h0001);

`ifdef RET_STACK_EN
    // Call at 0x0010 pushes 0x0011; a popping redirect returns there.
    clr_in();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0010;
    @(negedge clk);
    clr_in();
    chk("ras_fetch_addr", bus.imem_addr, 16'h0010);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = memf(16'h0010);
    @(negedge clk);
    clr_in();
    chk("ras_call_pc", bus.instr_pc, 16'h0010);
    bus.instr_ready = 1'b1;
    bus.call_push   = 1'b1;
    @(negedge clk);
    clr_in();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h5555;
    bus.ret_pop         = 1'b1;
    @(negedge clk);
    clr_in();
    chk("ras_return_pc", pc, 16'h0011);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
